hilo_unit: RTL and testbench

- Sequencer and HI/LO register file sitting between the main control unit and the multi-cycle multiplier/divider.
- Accepts start requests from control and issues single-cycle start strobes to the multiplier or divider.
- Waits for the unit's end flag, then captures the result into architectural HI/LO and signals completion, so control can stall on one busy line.
- Also services MTHI/MTLO writes and reports divide-by-zero and timeout.

---
 rtl/muldiv_pkg.sv | 13 +
 rtl/hilo_regs.sv | 39 +++
 rtl/hilo_unit.sv | 142 ++++++++++++++
 tb/tb_hilo_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO sequencer: state encoding and widths.
package muldiv_pkg;

    localparam int DATA_W          = 32;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_MULT = 2'd1,
        WAIT_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair with capture and MTHI/MTLO write muxing.
// Captures only happen in a wait state and writes only in IDLE, so the two
// paths never compete; the priority below is just a deterministic order.
module hilo_regs
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_mult,
    input  logic              cap_div,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic [DATA_W-1:0] mult_high,
    input  logic [DATA_W-1:0] mult_low,
    input  logic [DATA_W-1:0] div_rem,
    input  logic [DATA_W-1:0] div_quo,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    // Update HI/LO from a unit result or from an MTHI/MTLO write.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (cap_mult) begin
            hi <= mult_high;
            lo <= mult_low;
        end else if (cap_div) begin
            hi <= div_rem;
            lo <= div_quo;
        end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// Sequencer between control and the multi-cycle multiplier/divider.
// Handshake: control raises start_mult/start_div and holds it until busy is
// seen; busy rises on the edge after the request is sampled in IDLE and falls
// on the edge that produces exactly one of done/div0_exc/timeout.
module hilo_unit
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_mult,
    input  logic              start_div,
    output logic              mult_ctrl,
    output logic              div_ctrl,
    input  logic              mult_end,
    input  logic [DATA_W-1:0] mult_high,
    input  logic [DATA_W-1:0] mult_low,
    input  logic              div_end,
    input  logic [DATA_W-1:0] div_rem,
    input  logic [DATA_W-1:0] div_quo,
    input  logic              div_zero,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div0_exc,
    output logic              timeout
);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic idle;
    logic cnt_live;
    logic cnt_last;
    logic mult_fire;
    logic div_fire;
    logic cap_mult;
    logic cap_div;
    logic wr_hi;
    logic wr_lo;

    // The first wait cycle ignores end flags: the unit may still be showing
    // the level-high flag left over from the previous operation.
    assign idle      = (state == IDLE);
    assign cnt_live  = (cnt != '0);
    assign cnt_last  = (cnt == CNT_W'(TIMEOUT - 1));
    assign mult_fire = (state == WAIT_MULT) && cnt_live && mult_end;
    assign div_fire  = (state == WAIT_DIV) && cnt_live && div_end;
    assign cap_mult  = mult_fire;
    assign cap_div   = div_fire && !div_zero;
    assign wr_hi     = idle && mthi;
    assign wr_lo     = idle && mtlo;

    hilo_regs u_regs (
        .clk       (clk),
        .reset     (reset),
        .cap_mult  (cap_mult),
        .cap_div   (cap_div),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .mult_high (mult_high),
        .mult_low  (mult_low),
        .div_rem   (div_rem),
        .div_quo   (div_quo),
        .wdata     (wdata),
        .hi        (hi),
        .lo        (lo)
    );

    // Sequencer FSM: launch, wait with timeout, and registered status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mult_ctrl <= 1'b0;
            div_ctrl  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div0_exc  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            mult_ctrl <= 1'b0;
            div_ctrl  <= 1'b0;
            done      <= 1'b0;
            div0_exc  <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        mult_ctrl <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        state     <= WAIT_MULT;
                    end else if (start_div) begin
                        div_ctrl  <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        state     <= WAIT_DIV;
                    end
                end
                WAIT_MULT: begin
                    if (mult_fire) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt_last) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DIV: begin
                    if (div_fire) begin
                        if (div_zero) div0_exc <= 1'b1;
                        else          done     <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt_last) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: behavioural multiplier/divider models, a reference of
// the architectural HI/LO, and a result scoreboard drained by a monitor.
module tb_hilo_unit;

    localparam int TIMEOUT = 64;
    localparam logic [1:0] K_DONE = 2'd0;
    localparam logic [1:0] K_DIV0 = 2'd1;
    localparam logic [1:0] K_TMO  = 2'd2;

    logic        clk;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic        mult_ctrl;
    logic        div_ctrl;
    logic        mult_end;
    logic [31:0] mult_high;
    logic [31:0] mult_low;
    logic        div_end;
    logic [31:0] div_rem;
    logic [31:0] div_quo;
    logic        div_zero;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div0_exc;
    logic        timeout;

    int tests = 0;
    int fails = 0;

    // Scoreboard entries: {kind, hi, lo} expected at each status pulse.
    logic [65:0] exp_q[$];
    logic [65:0] mon_exp;
    logic [1:0]  mon_kind;

    // Reference architectural registers.
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;

    // Unit model settings, loaded by the driver tasks before a start.
    int          m_lat;
    int          m_cnt;
    logic [31:0] m_nxt_hi;
    logic [31:0] m_nxt_lo;
    int          d_lat;
    int          d_cnt;
    logic [31:0] d_nxt_rem;
    logic [31:0] d_nxt_quo;
    logic        d_nxt_zero;

    hilo_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start_mult(start_mult),
        .start_div (start_div),
        .mult_ctrl (mult_ctrl),
        .div_ctrl  (div_ctrl),
        .mult_end  (mult_end),
        .mult_high (mult_high),
        .mult_low  (mult_low),
        .div_end   (div_end),
        .div_rem   (div_rem),
        .div_quo   (div_quo),
        .div_zero  (div_zero),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .div0_exc  (div0_exc),
        .timeout   (timeout)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Multiplier model: end flag is a level that stays high until next start.
    always @(posedge clk) begin
        if (reset) begin
            mult_end  <= 1'b0;
            mult_high <= '0;
            mult_low  <= '0;
            m_cnt     <= 0;
        end else if (mult_ctrl) begin
            mult_end <= 1'b0;
            m_cnt    <= m_lat;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                mult_end  <= 1'b1;
                mult_high <= m_nxt_hi;
                mult_low  <= m_nxt_lo;
            end
        end
    end

    // Divider model, same level-style end flag.
    always @(posedge clk) begin
        if (reset) begin
            div_end  <= 1'b0;
            div_rem  <= '0;
            div_quo  <= '0;
            div_zero <= 1'b0;
            d_cnt    <= 0;
        end else if (div_ctrl) begin
            div_end <= 1'b0;
            d_cnt   <= d_lat;
        end else if (d_cnt > 0) begin
            d_cnt <= d_cnt - 1;
            if (d_cnt == 1) begin
                div_end  <= 1'b1;
                div_rem  <= d_nxt_rem;
                div_quo  <= d_nxt_quo;
                div_zero <= d_nxt_zero;
            end
        end
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every status pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!reset && (done || div0_exc || timeout)) begin
            check("pulse_onehot", 80'($countones({done, div0_exc, timeout})), 80'd1);
            mon_kind = done ? K_DONE : (div0_exc ? K_DIV0 : K_TMO);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 80'({done, div0_exc, timeout}), 80'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", 80'({mon_kind, hi, lo}), 80'(mon_exp));
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("busy_release", 80'(busy), 80'd0);
    endtask

    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
    endfunction

    task automatic run_mult(input logic [31:0] rh, input logic [31:0] rl, input int lat,
                            input bit with_div, input bit with_mthi, input logic [31:0] wd);
        m_nxt_hi = rh;
        m_nxt_lo = rl;
        m_lat    = lat;
        exp_q.push_back({K_DONE, rh, rl});
        mdl_hi = rh;
        mdl_lo = rl;
        start_mult = 1'b1;
        start_div  = with_div;
        mthi       = with_mthi;
        wdata      = wd;
        tick();
        start_mult = 1'b0;
        start_div  = 1'b0;
        mthi       = 1'b0;
        check("mult_launch", 80'({busy, mult_ctrl, div_ctrl, done}), 80'(4'b1100));
        if (with_mthi) check("mthi_with_start", 80'(hi), 80'(wd));
        tick();
        check("mult_strobe_len", 80'({busy, mult_ctrl, div_ctrl, done}), 80'(4'b1000));
        tick();
        check("mult_no_early", 80'({busy, done}), 80'(2'b10));
        wait_idle(TIMEOUT + 4);
        check("mult_hi", 80'(hi), 80'(mdl_hi));
        check("mult_lo", 80'(lo), 80'(mdl_lo));
    endtask

    // lat < 0 means the divider never answers; expect a timeout.
    task automatic run_div(input logic [31:0] rem, input logic [31:0] quo, input bit zero,
                           input int lat, input bit mt_in_wait);
        d_nxt_rem  = rem;
        d_nxt_quo  = quo;
        d_nxt_zero = zero;
        d_lat      = (lat < 0) ? 100000 : lat;
        if (lat < 0) begin
            exp_q.push_back({K_TMO, mdl_hi, mdl_lo});
        end else if (zero) begin
            exp_q.push_back({K_DIV0, mdl_hi, mdl_lo});
        end else begin
            exp_q.push_back({K_DONE, rem, quo});
            mdl_hi = rem;
            mdl_lo = quo;
        end
        start_div = 1'b1;
        tick();
        start_div = 1'b0;
        check("div_launch", 80'({busy, mult_ctrl, div_ctrl, done}), 80'(4'b1010));
        if (mt_in_wait) begin
            mthi  = 1'b1;
            mtlo  = 1'b1;
            wdata = 32'hDEADBEEF;
        end
        tick();
        check("div_strobe_len", 80'({busy, mult_ctrl, div_ctrl, done}), 80'(4'b1000));
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        check("div_no_early", 80'({busy, done, div0_exc}), 80'(3'b100));
        if (lat < 0) begin
            repeat (TIMEOUT - 3) tick();
            check("tmo_not_yet", 80'({busy, timeout}), 80'(2'b10));
            tick();
            check("tmo_pulse", 80'({busy, timeout, done}), 80'(3'b010));
        end else begin
            wait_idle(TIMEOUT + 4);
        end
        check("div_hi", 80'(hi), 80'(mdl_hi));
        check("div_lo", 80'(lo), 80'(mdl_lo));
    endtask

    task automatic mt_write(input bit h, input bit l, input logic [31:0] wd);
        mthi  = h;
        mtlo  = l;
        wdata = wd;
        if (h) mdl_hi = wd;
        if (l) mdl_lo = wd;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mt_hi", 80'(hi), 80'(mdl_hi));
        check("mt_lo", 80'(lo), 80'(mdl_lo));
        check("mt_quiet", 80'({busy, done, mult_ctrl, div_ctrl}), 80'd0);
    endtask

    // Main stimulus
    initial begin
        logic [63:0] p;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] dvd;
        logic [31:0] dvs;
        int          sel;

        reset = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
        wdata = '0;
        m_lat = 1;
        d_lat = 1;
        m_nxt_hi = '0;
        m_nxt_lo = '0;
        d_nxt_rem = '0;
        d_nxt_quo = '0;
        d_nxt_zero = 1'b0;
        mdl_hi = '0;
        mdl_lo = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_state",
              80'({hi, lo, busy, done, div0_exc, timeout, mult_ctrl, div_ctrl}), 80'd0);

        // 7 * -3
        p = mul_ref(32'd7, 32'hFFFFFFFD);
        run_mult(p[63:32], p[31:0], 3, 1'b0, 1'b0, '0);
        check("mult_7x-3", 80'({hi, lo}), 80'(64'hFFFFFFFF_FFFFFFEB));

        // mult_end still high from the previous multiply
        run_mult(32'h1, 32'h2, 4, 1'b0, 1'b0, '0);

        run_div(32'd3, 32'd5, 1'b0, 4, 1'b0);
        run_div(32'hAAAA5555, 32'h5555AAAA, 1'b1, 2, 1'b0);
        check("div0_retain", 80'({hi, lo}), 80'({32'd3, 32'd5}));

        // timeout with MTHI/MTLO attempted during the wait, then a fresh divide
        run_div(32'h0, 32'h0, 1'b0, -1, 1'b1);
        run_div(32'd9, 32'd11, 1'b0, 2, 1'b0);

        // both starts together: multiply wins
        p = mul_ref(32'd12345, 32'd678);
        run_mult(p[63:32], p[31:0], 2, 1'b1, 1'b0, '0);

        mt_write(1'b1, 1'b0, 32'hDEADBEEF);
        mt_write(1'b0, 1'b1, 32'h0BADF00D);
        mt_write(1'b1, 1'b1, 32'h12345678);

        // write and start in the same cycle; result overwrites
        p = mul_ref(32'hFFFF0000, 32'h00010001);
        run_mult(p[63:32], p[31:0], 5, 1'b0, 1'b1, 32'hCAFEF00D);

        // reset in the middle of a wait
        m_lat = 100000;
        start_mult = 1'b1;
        tick();
        start_mult = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mdl_hi = '0;
        mdl_lo = '0;
        check("reset_mid_wait",
              80'({hi, lo, busy, done, div0_exc, timeout, mult_ctrl, div_ctrl}), 80'd0);
        repeat (TIMEOUT + 6) tick();
        check("reset_aborted", 80'({busy, hi, lo}), 80'd0);

        // randomized operations
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: begin
                    a = $urandom;
                    b = $urandom;
                    p = mul_ref(a, b);
                    run_mult(p[63:32], p[31:0], $urandom_range(1, 8), 1'b0, 1'b0, '0);
                end
                1: begin
                    dvd = $urandom;
                    dvs = $urandom_range(0, 9);
                    if (dvs == 0)
                        run_div($urandom, $urandom, 1'b1, $urandom_range(1, 8), 1'b0);
                    else
                        run_div(dvd % dvs, dvd / dvs, 1'b0, $urandom_range(1, 8), 1'b0);
                end
                2: begin
                    if ($urandom_range(0, 1) == 1) mt_write(1'b1, 1'($urandom_range(0, 1)), $urandom);
                    else                           mt_write(1'b0, 1'b1, $urandom);
                end
                default: begin
                    a = $urandom;
                    b = $urandom;
                    p = mul_ref(a, b);
                    run_mult(p[63:32], p[31:0], $urandom_range(1, 8),
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
                end
            endcase
        end

        repeat (4) tick();
        check("scoreboard_drained", 80'(exp_q.size()), 80'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
